sampler_dma_csr: RTL

Parametrised control/status register file for the sampler DMA unit. It sits between the AXI-Lite slave controller and the per-voice DMA engines. Compared with the earlier DMA register bank, it adds a transfer-length register, a registered read path, byte-enable-qualified writes, self-clearing start/stop pulses, and latched per-voice events. Those events are write-1-to-clear and are aggregated into a single level interrupt.

---
 rtl/sampler_dma_csr.sv | 156 +++++++++++++++
 1 files changed

// File: rtl/sampler_dma_csr.sv
// Control/status register file for the sampler DMA voices: global ID/IRQ registers,
// per-voice base/length/control, sampled engine status, latched W1C events and level irq.
module sampler_dma_csr #(
   parameter int unsigned MAX_VOICES    = 16,
   parameter int unsigned ADDR_WIDTH    = 10,
   parameter int unsigned NUM_CTRL_REGS = 16,
   parameter logic [31:0] VERSION       = 32'h0000_0002
) (
   input  logic                   axi_clk,
   input  logic                   axi_reset,
   input  logic [31:0]            data_in,
   input  logic [3:0]             byte_enable,
   input  logic [ADDR_WIDTH-1:0]  reg_addr_wr,
   input  logic                   data_wren,
   input  logic [ADDR_WIDTH-1:0]  reg_addr_rd,
   input  logic                   rd_en,
   output logic [31:0]            data_out,
   output logic                   data_out_valid,
   output logic [31:0]            dma_base_addr [MAX_VOICES],
   output logic [31:0]            dma_length    [MAX_VOICES],
   output logic [MAX_VOICES-1:0]  dma_start,
   output logic [MAX_VOICES-1:0]  dma_stop,
   output logic [MAX_VOICES-1:0]  dma_loop_en,
   input  logic [31:0]            dma_status    [MAX_VOICES],
   input  logic [31:0]            dma_curr_addr [MAX_VOICES],
   input  logic [MAX_VOICES-1:0]  dma_done_evt,
   input  logic [MAX_VOICES-1:0]  dma_err_evt,
   output logic                   irq
);

   localparam int unsigned WORD_W     = ADDR_WIDTH - 3;
   localparam int unsigned CTRL_WORDS = NUM_CTRL_REGS / 8;

   logic [WORD_W-1:0]     wr_word, rd_word;
   logic [2:0]            wr_reg, rd_reg;
   logic [MAX_VOICES-1:0] wr_hit_c, done_clr_c, err_clr_c, pending_c;
   logic [MAX_VOICES-1:0] irq_en_q, done_q, err_q;
   logic [31:0]           status_q [MAX_VOICES];
   logic [31:0]           curr_q   [MAX_VOICES];
   logic [31:0]           scratch_q, rd_data_c;
   logic                  irq_global_en_q;

   assign wr_word = reg_addr_wr[ADDR_WIDTH-1:3];
   assign wr_reg  = reg_addr_wr[2:0];
   assign rd_word = reg_addr_rd[ADDR_WIDTH-1:3];
   assign rd_reg  = reg_addr_rd[2:0];

   function automatic logic [31:0] be_merge(input logic [31:0] old_v,
                                            input logic [31:0] new_v,
                                            input logic [3:0]  be);
      logic [31:0] res;
      for (int b = 0; b < 4; b++)
         res[8*b +: 8] = be[b] ? new_v[8*b +: 8] : old_v[8*b +: 8];
      return res;
   endfunction

   // Per-voice write decode; voice blocks are 8-word aligned above the global words
   always_comb begin
      wr_hit_c   = '0;
      done_clr_c = '0;
      err_clr_c  = '0;
      for (int v = 0; v < int'(MAX_VOICES); v++) begin
         wr_hit_c[v]   = data_wren && (wr_word == WORD_W'(CTRL_WORDS + v));
         done_clr_c[v] = wr_hit_c[v] && (wr_reg == 3'd5) && byte_enable[0] && data_in[0];
         err_clr_c[v]  = wr_hit_c[v] && (wr_reg == 3'd5) && byte_enable[0] && data_in[1];
      end
   end

   assign pending_c = (done_q | err_q) & irq_en_q;

   always_ff @(posedge axi_clk or negedge axi_reset) begin
      if (!axi_reset) begin
         for (int v = 0; v < int'(MAX_VOICES); v++) begin
            dma_base_addr[v] <= '0;
            dma_length[v]    <= '0;
            status_q[v]      <= '0;
            curr_q[v]        <= '0;
         end
         dma_start       <= '0;
         dma_stop        <= '0;
         dma_loop_en     <= '0;
         irq_en_q        <= '0;
         done_q          <= '0;
         err_q           <= '0;
         scratch_q       <= '0;
         irq_global_en_q <= 1'b0;
         irq             <= 1'b0;
      end else begin
         dma_start <= '0;
         dma_stop  <= '0;
         if (data_wren && reg_addr_wr == ADDR_WIDTH'(3) && byte_enable[0])
            irq_global_en_q <= data_in[0];
         if (data_wren && reg_addr_wr == ADDR_WIDTH'(5))
            scratch_q <= be_merge(scratch_q, data_in, byte_enable);
         for (int v = 0; v < int'(MAX_VOICES); v++) begin
            status_q[v] <= dma_status[v];
            curr_q[v]   <= dma_curr_addr[v];
            // A new event in the same cycle as its clear wins
            done_q[v]   <= dma_done_evt[v] | (done_q[v] & ~done_clr_c[v]);
            err_q[v]    <= dma_err_evt[v]  | (err_q[v]  & ~err_clr_c[v]);
            if (wr_hit_c[v]) begin
               case (wr_reg)
                  3'd0: dma_base_addr[v] <= be_merge(dma_base_addr[v], data_in, byte_enable);
                  3'd1: dma_length[v]    <= be_merge(dma_length[v], data_in, byte_enable);
                  3'd2: if (byte_enable[0]) begin
                     dma_start[v]   <= data_in[0];
                     dma_stop[v]    <= data_in[1];
                     dma_loop_en[v] <= data_in[2];
                     irq_en_q[v]    <= data_in[3];
                  end
                  default: ;
               endcase
            end
         end
         irq <= irq_global_en_q & (|pending_c);
      end
   end

   // Read mux from current state, so a same-cycle write is not yet visible
   always_comb begin
      rd_data_c = 32'hDEAD_DEAD;
      if (rd_word < WORD_W'(CTRL_WORDS)) begin
         rd_data_c = 32'hBEEF_DEAD;
         if (reg_addr_rd == ADDR_WIDTH'(0))      rd_data_c = VERSION;
         else if (reg_addr_rd == ADDR_WIDTH'(1)) rd_data_c = 32'(MAX_VOICES);
         else if (reg_addr_rd == ADDR_WIDTH'(2)) rd_data_c = 32'(NUM_CTRL_REGS);
         else if (reg_addr_rd == ADDR_WIDTH'(3)) rd_data_c = {31'b0, irq_global_en_q};
         else if (reg_addr_rd == ADDR_WIDTH'(4)) rd_data_c = 32'(pending_c);
         else if (reg_addr_rd == ADDR_WIDTH'(5)) rd_data_c = scratch_q;
      end
      for (int v = 0; v < int'(MAX_VOICES); v++) begin
         if (rd_word == WORD_W'(CTRL_WORDS + v)) begin
            case (rd_reg)
               3'd0:    rd_data_c = dma_base_addr[v];
               3'd1:    rd_data_c = dma_length[v];
               3'd2:    rd_data_c = {28'b0, irq_en_q[v], dma_loop_en[v], 2'b00};
               3'd3:    rd_data_c = status_q[v];
               3'd4:    rd_data_c = curr_q[v];
               3'd5:    rd_data_c = {30'b0, err_q[v], done_q[v]};
               default: rd_data_c = '0;
            endcase
         end
      end
   end

   always_ff @(posedge axi_clk or negedge axi_reset) begin
      if (!axi_reset) begin
         data_out       <= '0;
         data_out_valid <= 1'b0;
      end else begin
         data_out_valid <= rd_en;
         if (rd_en) data_out <= rd_data_c;
      end
   end

endmodule
